// File: rtl/lcd_cmd_host_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_host_if
//  Brief    : Upstream valid/ready and LCD_CTRL cmd/busy/done signal bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_cmd_host_if;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;

    // master is the sequencer itself (it initiates commands toward LCD_CTRL)
    modport master (
        input  in_cmd, in_valid, busy, done,
        output in_ready, cmd, cmd_valid
    );

    modport slave (
        output in_cmd, in_valid, busy, done,
        input  in_ready, cmd, cmd_valid
    );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_host.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_host
//  Brief    : Buffers upstream LCD commands and issues them to LCD_CTRL as
//             one-cycle strobes; optional busy timeout under LCD_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_cmd_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    lcd_cmd_host_if.master                bus,
    output logic                          seq_done,
    output logic                          cmd_err,
    output logic [CNT_W-1:0]              issued_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                  c_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL_LVL = (c_ADDR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GAP       = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FIN       = 2'd3
    } state_t;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1)
        begin : g_bad_param
            $error("lcd_cmd_host: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cmd, w_cmd_nxt;
    logic                   r_cmd_valid, w_cmd_valid_nxt;
    logic                   r_seq_done, w_seq_done_nxt;
    logic                   r_cmd_err, w_cmd_err_nxt;
    logic [CNT_W-1:0]       r_issued_cnt, w_issued_cnt_nxt;

    logic [3:0]             r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_ADDR_W:0]      r_level;

    logic                   w_full, w_empty, w_in_ready;
    logic                   w_hs, w_illegal, w_push, w_pop, w_flush;
    logic                   w_to_expire;

    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);

    // Readiness depends only on current occupancy; a same-cycle pop never frees a slot.
    assign w_in_ready = ~reset & ~w_full & ((r_state == S_IDLE) || (r_state == S_GAP));
    assign w_hs       = bus.in_valid & w_in_ready;
    assign w_illegal  = w_hs & (bus.in_cmd >= 4'd12);
    assign w_push     = w_hs & ~w_illegal;

`ifdef LCD_TIMEOUT_EN
    localparam int              c_TO_W = $clog2(TIMEOUT + 1);
    logic [c_TO_W-1:0]          r_to_cnt;
    logic                       w_to_active;

    assign w_to_active = bus.busy & ((r_state == S_IDLE) || (r_state == S_WAIT_DONE));
    assign w_to_expire = w_to_active & (r_to_cnt == c_TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_to_active && !w_to_expire) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_to_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_nxt        = r_cmd;
        w_cmd_valid_nxt  = 1'b0;
        w_seq_done_nxt   = r_seq_done;
        w_cmd_err_nxt    = r_cmd_err | w_illegal;
        w_issued_cnt_nxt = r_issued_cnt;
        w_pop            = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty && !bus.busy) begin
                    w_cmd_nxt        = r_mem[r_rd_ptr];
                    w_cmd_valid_nxt  = 1'b1;
                    w_pop            = 1'b1;
                    w_issued_cnt_nxt = (&r_issued_cnt) ? r_issued_cnt : r_issued_cnt + 1'b1;
                    w_state_nxt      = S_GAP;
                end
            end
            // busy is ignored here: LCD_CTRL raises it one cycle after the strobe
            S_GAP: begin
                w_state_nxt = (r_cmd == 4'd0) ? S_WAIT_DONE : S_IDLE;
            end
            S_WAIT_DONE: begin
                if (bus.done) begin
                    w_seq_done_nxt = 1'b1;
                    w_flush        = 1'b1;
                    w_state_nxt    = S_FIN;
                end
            end
            default: begin
                w_state_nxt = S_FIN;
            end
        endcase

        if (w_to_expire) begin
            w_state_nxt    = S_FIN;
            w_cmd_err_nxt  = 1'b1;
            w_seq_done_nxt = r_seq_done;
            w_flush        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cmd        <= 4'd0;
            r_cmd_valid  <= 1'b0;
            r_seq_done   <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_seq_done   <= w_seq_done_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_issued_cnt <= w_issued_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_cmd;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.cmd       = r_cmd;
    assign bus.cmd_valid = r_cmd_valid;
    assign seq_done      = r_seq_done;
    assign cmd_err       = r_cmd_err;
    assign issued_cnt    = r_issued_cnt;
    assign fifo_level    = r_level;

endmodule
`default_nettype wire
